// File: rtl/mm_stream_nxn_if.sv
// AXI-Stream style valid/ready bundle used on both sides of mm_stream_nxn.
// The slave view omits tlast because the input side does not use it.
interface mm_stream_nxn_if #(
  parameter int DW = 32
);
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic [DW-1:0] tdata;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    output tready
  );
endinterface

// File: rtl/mm_stream_nxn.sv
// Streaming N x N signed matrix multiplier C = A x B with one MAC lane.
// Optional: define MM_STREAM_SAT_EN to clamp C elements instead of wrapping.
module mm_stream_nxn #(
  parameter int N  = 4,
  parameter int DW = 32
) (
  input  logic            axis_clk,
  input  logic            axis_rst,
  input  logic            ap_start,
  input  logic            reuse_b,
  output logic            ap_idle,
  output logic            ap_done,
  mm_stream_nxn_if.slave  ss,
  mm_stream_nxn_if.master sm
);
  localparam int AW = 2*DW + $clog2(N);
  localparam int KW = $clog2(N);
  localparam int BW = $clog2(N*N);
  localparam logic [KW-1:0] KLAST = KW'(N-1);
  localparam logic [BW-1:0] BLAST = BW'(N*N-1);

  typedef enum logic [2:0] {
    IDLE, LOAD_B, LOAD_A, MAC, OUT, DONE
  } state_t;

  state_t state, state_n;

  logic [DW-1:0] b_buf [N*N];
  logic [DW-1:0] a_row [N];
  logic [KW-1:0] i, j, k;
  logic [BW-1:0] bcnt;
  logic [BW-1:0] bidx;
  logic          b_valid;
  logic          valid_q;
  logic [DW-1:0] data_q;
  logic [DW-1:0] res;
  logic          ss_hs, sm_hs;

  logic signed [AW-1:0]   acc, acc_n;
  logic signed [2*DW-1:0] a_ext, b_ext, prod;

  assign ap_idle   = (state == IDLE);
  assign ap_done   = (state == DONE);
  assign ss.tready = (state == LOAD_B) ||
                     (state == LOAD_A);
  assign sm.tvalid = valid_q;
  assign sm.tdata  = data_q;
  assign sm.tlast  = valid_q &&
                     (i == KLAST) &&
                     (j == KLAST);
  assign ss_hs     = ss.tvalid && ss.tready;
  assign sm_hs     = valid_q && sm.tready;

  // B is stored row-major, so column j of row k sits at k*N+j
  assign bidx  = BW'(k) * BW'(N) + BW'(j);
  assign a_ext = {{DW{a_row[k][DW-1]}}, a_row[k]};
  assign b_ext = {{DW{b_buf[bidx][DW-1]}}, b_buf[bidx]};
  assign prod  = a_ext * b_ext;
  assign acc_n = acc +
    {{(AW-2*DW){prod[2*DW-1]}}, prod};

`ifdef MM_STREAM_SAT_EN
  always_comb begin
    res = acc_n[DW-1:0];
    if (acc_n[AW-1:DW-1] !=
        {(AW-DW+1){acc_n[AW-1]}}) begin
      res = acc_n[AW-1] ?
        {1'b1, {(DW-1){1'b0}}} :
        {1'b0, {(DW-1){1'b1}}};
    end
  end
`else
  assign res = acc_n[DW-1:0];
`endif

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (ap_start)
          state_n = (reuse_b && b_valid) ?
                    LOAD_A : LOAD_B;
      end
      LOAD_B: begin
        if (ss_hs && bcnt == BLAST)
          state_n = LOAD_A;
      end
      LOAD_A: begin
        if (ss_hs && k == KLAST)
          state_n = MAC;
      end
      MAC: begin
        if (k == KLAST) state_n = OUT;
      end
      OUT: begin
        if (sm_hs) begin
          if (j != KLAST)      state_n = MAC;
          else if (i != KLAST) state_n = LOAD_A;
          else                 state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      i       <= '0;
      j       <= '0;
      k       <= '0;
      bcnt    <= '0;
      b_valid <= 1'b0;
      acc     <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      for (int n = 0; n < N*N; n++)
        b_buf[n] <= '0;
      for (int n = 0; n < N; n++)
        a_row[n] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ap_start) begin
            i    <= '0;
            j    <= '0;
            k    <= '0;
            bcnt <= '0;
          end
        end
        LOAD_B: begin
          if (ss_hs) begin
            b_buf[bcnt] <= ss.tdata;
            if (bcnt == BLAST) begin
              bcnt    <= '0;
              b_valid <= 1'b1;
            end else begin
              bcnt <= bcnt + BW'(1);
            end
          end
        end
        LOAD_A: begin
          if (ss_hs) begin
            a_row[k] <= ss.tdata;
            if (k == KLAST) begin
              k   <= '0;
              j   <= '0;
              acc <= '0;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        MAC: begin
          acc <= acc_n;
          if (k == KLAST) begin
            k       <= '0;
            data_q  <= res;
            valid_q <= 1'b1;
          end else begin
            k <= k + KW'(1);
          end
        end
        OUT: begin
          if (sm_hs) begin
            valid_q <= 1'b0;
            acc     <= '0;
            if (j != KLAST) begin
              j <= j + KW'(1);
            end else begin
              j <= '0;
              if (i != KLAST) i <= i + KW'(1);
              else            i <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mm_stream_nxn.sv
// Scoreboard bench for mm_stream_nxn: randomized and directed matrices
// checked against an arithmetic matrix-product model.
module tb_mm_stream_nxn;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 2*DW + $clog2(N);

  typedef logic signed [DW-1:0] el_t;
  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic axis_clk = 1'b0;
  logic axis_rst = 1'b1;
  logic ap_start = 1'b0;
  logic reuse_b  = 1'b0;
  logic ap_idle;
  logic ap_done;

  mm_stream_nxn_if #(.DW(DW)) ss_if();
  mm_stream_nxn_if #(.DW(DW)) sm_if();

  mm_stream_nxn #(.N(N), .DW(DW)) dut (
    .axis_clk (axis_clk),
    .axis_rst (axis_rst),
    .ap_start (ap_start),
    .reuse_b  (reuse_b),
    .ap_idle  (ap_idle),
    .ap_done  (ap_done),
    .ss       (ss_if),
    .sm       (sm_if)
  );

  always #5 axis_clk = ~axis_clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  el_t  na [N][N];
  el_t  nb [N][N];
  el_t  mb [N][N];
  bit   mb_valid = 1'b0;
  int   ss_cnt   = 0;
  int   done_cnt = 0;
  bit   bp_mode  = 1'b0;
  bit   abort    = 1'b0;
  bit   held_v   = 1'b0;
  logic [DW-1:0] held_d;
  int   stall    = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // C element from the exact dot product
  function automatic logic [DW-1:0] elem(
    input logic signed [AW-1:0] s);
`ifdef MM_STREAM_SAT_EN
    logic signed [AW-1:0] mx, mn;
    mx = (AW'(1) <<< (DW-1)) - 1;
    mn = -mx - 1;
    if (s > mx) return mx[DW-1:0];
    if (s < mn) return mn[DW-1:0];
`endif
    return s[DW-1:0];
  endfunction

  task automatic reset_checks(input string t);
    chk({t, "_ap_idle"},   ap_idle, 1);
    chk({t, "_ap_done"},   ap_done, 0);
    chk({t, "_ss_tready"}, ss_if.tready, 0);
    chk({t, "_sm_tvalid"}, sm_if.tvalid, 0);
    chk({t, "_sm_tdata"},  sm_if.tdata, 0);
    chk({t, "_sm_tlast"},  sm_if.tlast, 0);
  endtask

  task automatic send_word(input logic [DW-1:0] d);
    bit hs;
    int n;
    hs = 1'b0;
    n  = 0;
    if (abort) return;
    ss_if.tvalid = 1'b1;
    ss_if.tdata  = d;
    while (!hs && n < 2000) begin
      @(negedge axis_clk);
      hs = ss_if.tready;
      @(posedge axis_clk);
      #1;
      n++;
    end
    if (!hs) begin
      checks++;
      failures++;
      $display("FAIL ss_timeout: got no ready, expected ready");
      abort = 1'b1;
    end
    ss_if.tvalid = 1'b0;
    ss_if.tdata  = $urandom;
    if ($urandom_range(3) == 0) begin
      @(posedge axis_clk);
      #1;
    end
  endtask

  // cut < N: feed rows 0..cut, then reset while row cut is in MAC
  task automatic run_job(input bit reuse, input int cut);
    logic signed [AW-1:0] s;
    bit load_b;
    int ss0, d0, n, rows;
    if (abort) return;
    load_b = !(reuse && mb_valid);
    if (load_b) begin
      mb       = nb;
      mb_valid = 1'b1;
    end
    rows = (cut < N) ? cut : N;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < N; c++) begin
        s = '0;
        for (int q = 0; q < N; q++)
          s += AW'(na[r][q]) * AW'(mb[q][c]);
        exp_q.push_back('{data: elem(s),
          last: (r == N-1 && c == N-1)});
      end
    ss0 = ss_cnt;
    d0  = done_cnt;
    ap_start = 1'b1;
    reuse_b  = reuse;
    @(posedge axis_clk);
    #1;
    ap_start = 1'b0;
    reuse_b  = 1'($urandom_range(1));
    if (load_b)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          send_word(nb[r][c]);
    rows = (cut < N) ? cut + 1 : N;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < N; c++)
        send_word(na[r][c]);
    if (abort) return;
    if (cut < N) begin
      @(posedge axis_clk);
      #1;
      axis_rst = 1'b1;
      mb_valid = 1'b0;
      @(negedge axis_clk);
      reset_checks("midrst");
      chk("midrst_queue", exp_q.size(), 0);
      @(posedge axis_clk);
      #1;
      axis_rst = 1'b0;
      return;
    end
    n = 0;
    while (!(exp_q.size() == 0 && ap_idle &&
             done_cnt != d0) && n < 3000) begin
      @(posedge axis_clk);
      #1;
      n++;
    end
    chk("job_complete", n < 3000, 1);
    if (n >= 3000) abort = 1'b1;
    chk("done_pulses", done_cnt - d0, 1);
    chk("ss_words", ss_cnt - ss0,
        load_b ? 2*N*N : N*N);
  endtask

  task automatic rand_mats();
    int mode;
    mode = $urandom_range(2);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        if (mode == 0) begin
          na[r][c] = $urandom;
          nb[r][c] = $urandom;
        end else if (mode == 1) begin
          na[r][c] = el_t'($urandom_range(16)) - 8;
          nb[r][c] = el_t'($urandom_range(16)) - 8;
        end else begin
          na[r][c] = $urandom_range(1) ?
            el_t'(32'h7FFF_FFFF) : el_t'(32'h8000_0000);
          nb[r][c] = $urandom_range(1) ?
            el_t'(32'h7FFF_FFFF) : el_t'(32'h8000_0000);
        end
      end
  endtask

  always @(posedge axis_clk) begin
    #1;
    if (!bp_mode) begin
      sm_if.tready = ($urandom_range(3) != 0);
    end else if (sm_if.tvalid && !sm_if.tready) begin
      stall++;
      if (stall >= 5) sm_if.tready = 1'b1;
    end else begin
      sm_if.tready = 1'b0;
      stall = 0;
    end
  end

  always @(negedge axis_clk) begin
    exp_t e;
    if (axis_rst) begin
      held_v = 1'b0;
    end else begin
      if (ss_if.tvalid && ss_if.tready) ss_cnt++;
      if (ap_done) done_cnt++;
      if (held_v) begin
        chk("stall_valid", sm_if.tvalid, 1);
        chk("stall_data", sm_if.tdata, held_d);
      end
      if (sm_if.tvalid && sm_if.tready) begin
        held_v = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_output: got %0h, expected none",
                   sm_if.tdata);
        end else begin
          e = exp_q.pop_front();
          chk("c_data", sm_if.tdata, e.data);
          chk("c_last", sm_if.tlast, e.last);
        end
      end else if (sm_if.tvalid) begin
        held_v = 1'b1;
        held_d = sm_if.tdata;
      end else begin
        held_v = 1'b0;
        chk("tlast_idle", sm_if.tlast, 0);
      end
    end
  end

  initial begin
    ss_if.tvalid = 1'b0;
    ss_if.tdata  = '0;
    ss_if.tlast  = 1'b0;
    sm_if.tready = 1'b0;
    @(negedge axis_clk);
    reset_checks("reset");
    @(posedge axis_clk);
    #1;
    axis_rst = 1'b0;

    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        na[r][c] = el_t'(r*N + c + 1);
        nb[r][c] = (r == c) ? el_t'(1) : el_t'(0);
      end
    run_job(1'b0, N);

    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        na[r][c] = el_t'(-1);
        nb[r][c] = el_t'(2);
      end
    run_job(1'b0, N);

    bp_mode = 1'b1;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        na[r][c] = el_t'(3);
        nb[r][c] = el_t'(2);
      end
    run_job(1'b0, N);
    bp_mode = 1'b0;

    rand_mats();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        na[r][c] = (r == c) ? el_t'(1) : el_t'(0);
    run_job(1'b1, N);

    for (int t = 0; t < 6; t++) begin
      rand_mats();
      run_job(1'($urandom_range(1)), N);
    end

    rand_mats();
    run_job(1'b0, 2);
    rand_mats();
    run_job(1'b1, N);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/mm_stream_nxn.md
Name: mm_stream_nxn

Overview:
- Parametrised streaming matrix multiplier, C = A x B, with N x N signed operands; successor to the fixed 4x4 mm block.
- Sits between the DMA AXI-Stream input (ss_*) and output (sm_*) ports, and is started by an ap_start pulse from the DMA controller.
- Uses one sequential MAC lane. B is held in a register buffer and can be reused across consecutive A matrices without reloading.

Parameters:
- N, 4: matrix dimension; legal range 2..8.
- DW, 32: element width, signed two's complement, for A, B and C.
- AW, 2*DW+$clog2(N): accumulator width (derived localparam, not overridable).

Ports:
- axis_clk  in  1  clock.
- axis_rst  in  1  asynchronous, active-high reset.
- ap_start  in  1  start pulse; sampled only in IDLE.
- reuse_b  in  1  sampled with ap_start; 1 = skip B load if the B buffer is valid.
- ap_idle  out  1  high in IDLE.
- ap_done  out  1  one-cycle pulse after the last C element handshakes.
- ss_tvalid  in  1  input stream valid.
- ss_tdata  in  DW  input stream data.
- ss_tready  out  1  input stream ready.
- sm_tready  in  1  output stream ready.
- sm_tvalid  out  1  output stream valid.
- sm_tdata  out  DW  output stream data.
- sm_tlast  out  1  high with the final C element (row N-1, column N-1).

Behaviour:
- Reset values: ap_idle=1; ap_done, ss_tready, sm_tvalid, sm_tdata, sm_tlast=0. Also cleared: all counters, accumulator, b_valid flag, and the A/B buffers.
- Reset asserted mid-operation aborts immediately. No output is generated and no handshake completes while axis_rst=1.
- State IDLE: ss_tready=0. On ap_start=1:
  - go to LOAD_A if reuse_b=1 and b_valid=1;
  - otherwise go to LOAD_B.
  - ap_start in any other state is ignored.
- State LOAD_B: ss_tready=1. Accepts N*N words, row-major (B[0][0], B[0][1], ...), one per ss handshake. On the last word, set b_valid=1 and go to LOAD_A.
- State LOAD_A: ss_tready=1. Accepts N words of row i (A[i][0..N-1]). After the N-th word, go to MAC with column j=0.
- State MAC: ss_tready=0. acc cleared on entry; k runs 0..N-1, acc += A[i][k]*B[k][j] (sign-extended to AW), one term per cycle.
  - The edge that adds the k=N-1 term also loads sm_tdata and sets sm_tvalid=1; go to OUT.
  - sm_tvalid rises exactly N cycles after the ss handshake edge that entered MAC.
- State OUT: sm_tvalid and sm_tdata held stable until sm_tvalid && sm_tready. On that handshake edge, sm_tvalid drops. Then:
  - j<N-1: j++, go to MAC;
  - j=N-1 and i<N-1: i++, go to LOAD_A;
  - j=N-1 and i=N-1: go to DONE.
- sm_tlast=1 only while sm_tvalid and i=N-1, j=N-1.
- State DONE: ap_done=1 for one cycle, then IDLE. b_valid is retained.
- Width rule (default build): sm_tdata = acc[DW-1:0], i.e. wrap-around truncation.
- Throughput: N+1 cycles minimum per C element (N MAC cycles plus the OUT handshake cycle).
- ss_tvalid low while loading: the block waits with no counter advance. ss_tdata is ignored whenever ss_tready=0.
- Output back-pressure: any number of stall cycles. Counters freeze; no element is lost or duplicated.

Optional Feature:
- Macro MM_STREAM_SAT_EN.
- Defined: sm_tdata = acc clamped to [-2^(DW-1), 2^(DW-1)-1].
- Undefined: plain truncation to acc[DW-1:0].
- Cycle timing is identical in both builds.

Test Plan:
- Basic product (N=4, DW=32):
  - Stimulus: B=identity, A rows [1,2,3,4], [5,6,7,8], [9,10,11,12], [13,14,15,16].
  - Response: 16 outputs equal to A row-major; sm_tlast only on value 16; ap_done pulses once.
- Signed values:
  - Stimulus: A all -1 (0xFFFFFFFF), B all 2.
  - Response: every output -8 (0xFFFFFFF8).
- Output back-pressure:
  - Stimulus: A all 3, B all 2; sm_tready held low 5 cycles at each output.
  - Response: sm_tdata stable at 24 across each stall; exactly 16 outputs.
- B reuse:
  - Stimulus: second ap_start with reuse_b=1, new A=identity.
  - Response: ss_tready is 0 for B (only 16 A words consumed); outputs equal the previous B.
- Saturation (DW=8, N=4):
  - Stimulus: A=B=all 127.
  - Response: with MM_STREAM_SAT_EN, every output 127 (0x7F); without it, 64516 -> 0x04.
- Reset mid-operation:
  - Stimulus: assert axis_rst during MAC of row 2, then deassert.
  - Response: all outputs at reset values, ap_idle=1, b_valid cleared (a later reuse_b=1 start loads B).
